decoder_nto2n_seq: RTL
======================

DECODER_NTO2N_SEQ -- requirements
Module: decoder_nto2n_seq

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, meaning select width; legal range 1..6.
REQ-002 The block SHALL have parameter DIV_W, default 8, meaning scan prescaler width.
REQ-003 The block SHALL have localparam OUT_W = 2**SEL_W, meaning one-hot output width.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-006 The block SHALL have port en  input  1  meaning enable; low forces out to zero.
REQ-007 The block SHALL have port mode  input  1  meaning 0 = DIRECT, 1 = SCAN.
REQ-008 The block SHALL have port sel_in  input  SEL_W  meaning decode index (DIRECT) or load value (SCAN).
REQ-009 The block SHALL have port sel_load  input  1  meaning in SCAN, load sel_in into the index.
REQ-010 The block SHALL have port div  input  DIV_W  meaning scan dwell, in cycles minus one, per position.
REQ-011 The block SHALL have port out  output  OUT_W  meaning registered one-hot output, or all zero.
REQ-012 The block SHALL have port idx  output  SEL_W  meaning registered current index.
REQ-013 The block SHALL have port wrap  output  1  meaning one-cycle pulse when the scan index wraps from OUT_W-1 to 0.

Function
REQ-014 The FSM SHALL have states IDLE, DIRECT and SCAN.
REQ-015 In any state, the FSM SHALL go to IDLE in the next cycle when en=0.
REQ-016 When en=1, the FSM SHALL go to DIRECT if mode=0, else to SCAN, in the next cycle.
REQ-017 In IDLE, the block SHALL drive out = 0 and wrap = 0, retain idx, and hold the prescaler counter at 0.
REQ-018 In DIRECT, the block SHALL register idx <= sel_in and out <= one-hot(sel_in), giving a latency of 1 cycle from a sel_in change to out.
REQ-019 In SCAN, the prescaler counter SHALL increment each cycle.
REQ-020 In SCAN, a tick SHALL occur when counter >= div; on a tick the counter clears and idx advances by 1 modulo OUT_W.
REQ-021 REQ-020 SHALL imply that div=0 advances idx every cycle, and that a mid-count reduction of div ticks on the next cycle.
REQ-022 In SCAN, out SHALL equal one-hot(idx) at all times, registered together with idx.
REQ-023 wrap SHALL assert for exactly the cycle in which out = bit 0 following an advance from OUT_W-1; a wrap caused by load or by DIRECT SHALL NOT assert wrap.
REQ-024 When sel_load=1 in SCAN, idx SHALL be set to sel_in and the counter cleared; if sel_load and a tick coincide, the load SHALL win.
REQ-025 sel_load SHALL be ignored outside SCAN.
REQ-026 Any mode change or entry into SCAN SHALL clear the counter, and scanning SHALL resume from the retained idx.
REQ-027 out SHALL never have more than one bit set.
REQ-028 idx SHALL never be outside 0..OUT_W-1.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter state IDLE and SHALL set out=0, idx=0, wrap=0 and counter=0.
REQ-030 rst SHALL take priority over every other input, including a reset asserted mid-scan.
REQ-031 On the first edge after rst falls with en=1, the FSM SHALL enter DIRECT or SCAN, and the first valid out SHALL appear on the following edge.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/DIRECT/SCAN) and the mode constants MODE_DIRECT=0 and MODE_SCAN=1.
REQ-033 The prescaler SHALL be a sub-module named scan_prescaler, with parameter DIV_W, inputs clk/rst/run/clear/div and output tick.
REQ-034 The one-hot decode SHALL be a parameterised combinational function sized by SEL_W, with no case list fixed to 8 entries.

Verification
REQ-035 The bench SHALL cover: SEL_W=3, en=1, mode=0, sel_in stepping 0..7 -> out = 0x01,0x02,...,0x80 each one cycle later; en=0 -> out = 0x00 next cycle.
REQ-036 The bench SHALL cover: SCAN with div=2 from idx=0 -> idx changes every 3 cycles through 0..7,0, with wrap=1 for exactly one cycle when out returns to 0x01.
REQ-037 The bench SHALL cover: SCAN with div=0 and sel_load=1, sel_in=5 on the same cycle as a tick -> idx=5, out=0x20, then 6 on the next cycle, with no wrap.
REQ-038 The bench SHALL cover: mid-scan idx=3, en dropped for 4 cycles then re-raised -> out=0 while low, then resumes at out=0x08 with the counter restarted.
REQ-039 The bench SHALL cover: rst pulsed for 1 cycle mid-scan at idx=6 -> next cycle out=0x00, idx=0, wrap=0.
REQ-040 The bench SHALL cover: SEL_W=1 and SEL_W=6 builds, full scan with div=1 -> out stays one-hot at every cycle and wrap occurs every 2*OUT_W cycles.

Source files
------------

// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared types and constants for the sequenced N-to-2^N decoder.
package decoder_nto2n_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_nto2n_seq_scan_prescaler.sv
// Dwell prescaler for scan mode.
// The counter runs only while the scan is active and otherwise sits at zero,
// so every entry into scan starts a fresh dwell period. tick is asserted
// combinationally once the count reaches div. The compare is >= rather than ==
// so that lowering div below the current count ticks on the very next cycle.
module scan_prescaler
    import decoder_nto2n_seq_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = run && (cnt >= div);

    // Count up while running; restart on tick, clear, reset or when idle.
    always_ff @(posedge clk) begin
        if (rst || !run || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Sequenced N-to-2^N decoder: direct one-hot decode of sel_in, or a timed
// scan that walks a one-hot bit across all outputs.
//
// state  | meaning
// IDLE   | disabled: out and wrap held low, idx retained, prescaler at zero
// DIRECT | out/idx follow sel_in with one cycle of latency
// SCAN   | idx advances on each prescaler tick, sel_load reloads idx
//
// All outputs are registered. Dropping en zeroes out on the next edge,
// whatever the current state.
module decoder_nto2n_seq
    import decoder_nto2n_seq_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  sel_load,
    input  logic [DIV_W-1:0]      div,
    output logic [(2**SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] idx_nxt;
    logic [OUT_W-1:0] out_nxt;
    logic             wrap_nxt;
    logic             run;
    logic             tick;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    assign run = (state == SCAN) && en;

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (sel_load),
        .div   (div),
        .tick  (tick)
    );

    // Next state and next output values; a load beats a coincident tick.
    always_comb begin
        state_nxt = IDLE;
        idx_nxt   = idx;
        out_nxt   = '0;
        wrap_nxt  = 1'b0;
        if (en) begin
            state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
            unique case (state)
                DIRECT: begin
                    idx_nxt = sel_in;
                    out_nxt = onehot(sel_in);
                end
                SCAN: begin
                    if (sel_load) begin
                        idx_nxt = sel_in;
                    end else if (tick) begin
                        idx_nxt  = idx + 1'b1;
                        wrap_nxt = &idx;
                    end
                    out_nxt = onehot(idx_nxt);
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            out   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            out   <= out_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule
